// File: rtl/uart_lite_pkg.sv
// uart_lite_pkg: shared states and sizing for the UART-lite TX path.
package uart_lite_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        FLUSH = 2'd2
    } tx_state_e;

    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_COUNT_W = $clog2(DEFAULT_DEPTH) + 1;

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: feeds host writes into the TX FIFO and drains it to the serializer.
module uart_tx_fifo_ctrl
    import uart_lite_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LOW_WM = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      flush_i,
    input  logic                      host_wr_i,
    input  logic [WIDTH-1:0]          host_data_i,
    input  logic                      overrun_clr_i,
    output logic                      fifo_wr_o,
    output logic [WIDTH-1:0]          fifo_data_o,
    output logic                      fifo_rd_o,
    output logic                      fifo_rst_o,
    input  logic [WIDTH-1:0]          fifo_data_i,
    input  logic                      fifo_empty_i,
    input  logic                      fifo_full_i,
    input  logic [count_w(DEPTH)-1:0] fifo_count_i,
    output logic                      tx_valid_o,
    output logic [WIDTH-1:0]          tx_data_o,
    input  logic                      tx_ready_i,
    output logic                      overrun_o,
    output logic                      irq_watermark_o,
    output logic                      idle_o
);

    localparam int CW = count_w(DEPTH);

    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             overrun_q, overrun_d;
    logic             irq_q, irq_d;
    logic             pop;

    assign pop = ~fifo_empty_i & enable_i & ~flush_i &
                 ((state_q == IDLE) | ((state_q == VALID) & tx_ready_i));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = flush_i ? FLUSH : (pop ? VALID : IDLE);
            VALID:   state_d = tx_ready_i ? (pop ? VALID : IDLE) : (flush_i ? FLUSH : VALID);
            FLUSH:   state_d = flush_i ? FLUSH : IDLE;
            default: state_d = IDLE;
        endcase
        tx_data_d = (state_q == FLUSH) ? '0 : (pop ? fifo_data_i : tx_data_q);
        // a write that lands on a full FIFO only loses data when nothing is popped alongside it
        overrun_d = (fifo_wr_o & fifo_full_i & ~pop) | (overrun_q & ~overrun_clr_i);
        irq_d     = enable_i & (fifo_count_i <= CW'(LOW_WM));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    assign fifo_wr_o       = host_wr_i & (state_q != FLUSH);
    assign fifo_data_o     = host_data_i;
    assign fifo_rd_o       = pop;
    assign fifo_rst_o      = ~rst_ni | (state_q == FLUSH);
    assign tx_valid_o      = (state_q == VALID);
    assign tx_data_o       = tx_data_q;
    assign overrun_o       = overrun_q;
    assign irq_watermark_o = irq_q;
    assign idle_o          = (state_q == IDLE) & fifo_empty_i;

    a_rd_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_rd_o && fifo_empty_i));
    a_rd_rst:      assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_rd_o && fifo_rst_o));
    a_data_hold:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    tx_valid_o && !tx_ready_i |=> $stable(tx_data_o));

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl: directed and random stimulus against a queue-based model of FIFO plus controller.
module tb_uart_tx_fifo_ctrl;

    localparam int DEPTH  = 16;
    localparam int WIDTH  = 8;
    localparam int LOW_WM = 2;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             en, flush, host_wr, ready, clr;
    logic [WIDTH-1:0] host_data;
    logic             fifo_wr_o, fifo_rd_o, fifo_rst_o;
    logic [WIDTH-1:0] fifo_data_o, tx_data_o;
    logic [WIDTH-1:0] f_data;
    logic             f_empty, f_full;
    logic [4:0]       f_count;
    logic             tx_valid_o, overrun_o, irq_watermark_o, idle_o;

    always #5 clk = ~clk;

    uart_tx_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LOW_WM(LOW_WM)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(en), .flush_i(flush),
        .host_wr_i(host_wr), .host_data_i(host_data), .overrun_clr_i(clr),
        .fifo_wr_o(fifo_wr_o), .fifo_data_o(fifo_data_o), .fifo_rd_o(fifo_rd_o),
        .fifo_rst_o(fifo_rst_o), .fifo_data_i(f_data), .fifo_empty_i(f_empty),
        .fifo_full_i(f_full), .fifo_count_i(f_count), .tx_valid_o(tx_valid_o),
        .tx_data_o(tx_data_o), .tx_ready_i(ready), .overrun_o(overrun_o),
        .irq_watermark_o(irq_watermark_o), .idle_o(idle_o)
    );

    // Model: FIFO contents, the word on offer to the serializer, and whether a flush cycle is running.
    logic [WIDTH-1:0] q[$];
    logic             m_has, m_flush, m_ov, m_irq;
    logic [WIDTH-1:0] m_data;
    int               passed = 0;
    int               total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive();
        f_empty = (q.size() == 0);
        f_full  = (q.size() == DEPTH);
        f_count = 5'(q.size());
        f_data  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic model_reset();
        m_has = 0; m_flush = 0; m_ov = 0; m_irq = 0; m_data = '0;
    endtask

    task automatic cyc();
        logic pop, wr, n_has, n_flush, n_ov, n_irq;
        logic [WIDTH-1:0] n_data;
        #1;
        pop = (q.size() != 0) && en && !flush && !m_flush && (!m_has || ready);
        wr  = host_wr && !m_flush;
        chk("fifo_wr", fifo_wr_o, wr);
        chk("fifo_data", fifo_data_o, host_data);
        chk("fifo_rd", fifo_rd_o, pop);
        chk("fifo_rst", fifo_rst_o, m_flush);
        chk("tx_valid", tx_valid_o, m_has);
        chk("tx_data", tx_data_o, m_data);
        chk("overrun", overrun_o, m_ov);
        chk("irq", irq_watermark_o, m_irq);
        chk("idle", idle_o, !m_has && !m_flush && q.size() == 0);
        n_flush = flush && !(m_has && ready);
        n_has   = pop || (m_has && !ready && !flush);
        n_data  = m_flush ? '0 : (pop ? q[0] : m_data);
        n_ov    = (wr && q.size() == DEPTH && !pop) || (m_ov && !clr);
        n_irq   = en && (q.size() <= LOW_WM);
        if (m_flush) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (wr) begin
                if (q.size() == DEPTH) void'(q.pop_front());
                q.push_back(host_data);
            end
        end
        @(posedge clk);
        #1;
        m_has = n_has; m_flush = n_flush; m_data = n_data; m_ov = n_ov; m_irq = n_irq;
        drive();
    endtask

    initial begin
        rst_ni = 0; en = 0; flush = 0; host_wr = 0; ready = 0; clr = 0; host_data = '0;
        model_reset();
        drive();
        #2;
        chk("rst_valid", tx_valid_o, 0);
        chk("rst_data", tx_data_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_irq", irq_watermark_o, 0);
        chk("rst_fifo_rst", fifo_rst_o, 1);
        @(posedge clk);
        #1 rst_ni = 1;

        // single word: pop one cycle after the write, presented the next
        en = 1; ready = 1; host_wr = 1; host_data = 8'hA5;
        cyc();
        host_wr = 0;
        #1 chk("s1_rd", fifo_rd_o, 1);
        cyc();
        #1 chk("s1_valid", tx_valid_o, 1);
        chk("s1_data", tx_data_o, 8'hA5);
        cyc();
        #1 chk("s1_idle", idle_o, 1);

        // back-to-back stream of four words
        en = 0;
        for (int i = 1; i <= 4; i++) begin
            host_wr = 1; host_data = 8'(i); cyc();
        end
        host_wr = 0; en = 1; ready = 1;
        cyc();
        for (int i = 1; i <= 4; i++) begin
            #1 chk("s2_valid", tx_valid_o, 1);
            chk("s2_data", tx_data_o, i);
            cyc();
        end

        // stalled word survives enable drop
        ready = 0; en = 1; host_wr = 1; host_data = 8'h10;
        cyc();
        host_data = 8'h11;
        cyc();
        host_wr = 0; en = 0;
        repeat (2) begin
            #1 chk("s3_hold", tx_data_o, 8'h10);
            chk("s3_no_rd", fifo_rd_o, 0);
            cyc();
        end
        ready = 1;
        cyc();
        #1 chk("s3_released", tx_valid_o, 0);
        flush = 1; cyc();
        flush = 0; cyc();

        // overrun on write-while-full, none when a pop coincides
        en = 0; ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            host_wr = 1; host_data = 8'(8'h20 + i); cyc();
        end
        host_data = 8'hEE;
        cyc();
        host_wr = 0;
        #1 chk("s4_overrun", overrun_o, 1);
        clr = 1; cyc();
        clr = 0;
        #1 chk("s4_cleared", overrun_o, 0);
        en = 1; ready = 1; host_wr = 1; host_data = 8'hEF;
        cyc();
        host_wr = 0;
        #1 chk("s4_no_overrun", overrun_o, 0);
        repeat (20) cyc();

        // flush while presenting with words queued
        en = 1; ready = 0;
        for (int i = 0; i < 6; i++) begin
            host_wr = 1; host_data = 8'(8'h40 + i); cyc();
        end
        host_wr = 0;
        cyc();
        flush = 1; cyc();
        flush = 0; host_wr = 1; host_data = 8'h77;
        #1 chk("s5_rst", fifo_rst_o, 1);
        chk("s5_valid", tx_valid_o, 0);
        chk("s5_wr_drop", fifo_wr_o, 0);
        cyc();
        host_wr = 0;
        #1 chk("s5_idle", idle_o, 1);

        // asynchronous reset mid-stream
        en = 1; ready = 1;
        for (int i = 0; i < 3; i++) begin
            host_wr = 1; host_data = 8'(8'h50 + i); cyc();
        end
        host_wr = 0;
        #2 rst_ni = 0;
        #1 chk("s6_valid", tx_valid_o, 0);
        chk("s6_fifo_rst", fifo_rst_o, 1);
        chk("s6_data", tx_data_o, 0);
        model_reset();
        @(posedge clk);
        #1 q.delete();
        drive();
        rst_ni = 1;

        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(3) != 0);
            ready     = $urandom_range(1);
            host_wr   = $urandom_range(1);
            host_data = 8'($urandom);
            flush     = ($urandom_range(19) == 0);
            clr       = ($urandom_range(15) == 0);
            if (i % 100 < 30) begin
                en = 0; host_wr = 1;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
Transmit-side controller for the UART-lite wrapping FIFO (DEPTH x WIDTH, drop-oldest on write-when-full).
- Forwards host writes into the FIFO.
- Drains the FIFO into the UART serializer over a valid/ready handshake.
- Sequences FIFO flush.
- Flags overruns and raises a low-watermark interrupt.
- Sits between the register interface and both the FIFO instance and the TX serializer; the FIFO is instantiated alongside, not inside.

Parameters:
DEPTH, 16, FIFO depth in words; power of two.
WIDTH, 8, data word width.
LOW_WM, 2, watermark; irq asserts while count <= LOW_WM; range 0..DEPTH.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
enable_i  in  1  permit draining FIFO to serializer
flush_i  in  1  request FIFO flush (level, sampled each edge)
host_wr_i  in  1  host write strobe
host_data_i  in  WIDTH  host write data
overrun_clr_i  in  1  clear sticky overrun flag
fifo_wr_o  out  1  FIFO write strobe
fifo_data_o  out  WIDTH  FIFO write data
fifo_rd_o  out  1  FIFO pop strobe
fifo_rst_o  out  1  FIFO synchronous reset, active-high
fifo_data_i  in  WIDTH  FIFO head word (valid while fifo_empty_i=0; pop takes effect at the edge)
fifo_empty_i  in  1  FIFO empty
fifo_full_i  in  1  FIFO full
fifo_count_i  in  $clog2(DEPTH)+1  FIFO occupancy
tx_valid_o  out  1  word presented to serializer
tx_data_o  out  WIDTH  presented word (registered)
tx_ready_i  in  1  serializer accepts word
overrun_o  out  1  sticky: a host write dropped the oldest word
irq_watermark_o  out  1  occupancy at/below LOW_WM while enabled
idle_o  out  1  state IDLE and FIFO empty

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - State goes to IDLE.
  - tx_valid_o, tx_data_o, overrun_o and irq_watermark_o go to 0.
  - fifo_rst_o = 1 combinationally while rst_ni=0, so the FIFO clears with the controller.
- States: IDLE, VALID, FLUSH (2-bit encoding).
- Host path: fifo_wr_o = host_wr_i & (state != FLUSH); fifo_data_o = host_data_i; both combinational. Host writes in FLUSH are discarded.
- Pop rule: pop = ~fifo_empty_i & enable_i & ~flush_i & (state==IDLE | (state==VALID & tx_ready_i)).
  - fifo_rd_o = pop, combinational.
  - On pop, tx_data_o <= fifo_data_i.
- IDLE:
  - flush_i -> FLUSH.
  - Else pop -> VALID.
  - Else stay.
  - tx_valid_o = 0.
- VALID:
  - tx_valid_o = 1; tx_data_o is held stable until tx_ready_i.
  - On tx_ready_i: pop -> stay VALID (back-to-back, 1 word/cycle); no pop -> IDLE.
  - flush_i without tx_ready_i -> FLUSH; the presented word is abandoned.
  - enable_i deassert does not withdraw a presented word. It only blocks further pops.
- FLUSH:
  - Lasts exactly one cycle: fifo_rst_o=1, tx_valid_o=0, tx_data_o <= 0.
  - Next state: IDLE, or FLUSH again if flush_i is still high.
- Latency:
  - Non-empty FIFO in IDLE to tx_valid_o: 1 cycle.
  - Host write into an empty FIFO to tx_valid_o: 2 cycles.
- Overrun:
  - Set at the edge when fifo_wr_o & fifo_full_i & ~fifo_rd_o.
  - Cleared by overrun_clr_i; set wins over clear in the same cycle.
  - Write-while-full with a simultaneous pop is not an overrun.
  - Flush does not clear overrun.
- Watermark: irq_watermark_o registered, = enable_i & (fifo_count_i <= LOW_WM). The comparison uses the full count width; count==DEPTH never matches unless LOW_WM==DEPTH.
- Invariants (assert in formal):
  - tx_valid_o implies state==VALID.
  - fifo_rd_o never with fifo_empty_i.
  - fifo_rd_o and fifo_rst_o never together after reset.
  - tx_data_o is stable while tx_valid_o & ~tx_ready_i.

Decomposition:
- Shared package uart_lite_pkg: state enum (IDLE=0, VALID=1, FLUSH=2), DEFAULT_DEPTH, DEFAULT_WIDTH, and a count-width helper constant.
- No sub-module; the FIFO and serializer are instantiated by the parent, and the controller is one FSM plus two flag registers.

Test Plan:
- Reset release, write 0xA5 at cycle 0, enable=1, ready=1 -> fifo_rd_o pulses cycle 1; tx_valid_o=1, tx_data_o=0xA5 cycle 2; idle_o=1 cycle 3.
- 4 words 0x01..0x04 queued, ready held 1 -> tx_valid_o high 4 consecutive cycles, data 0x01,0x02,0x03,0x04; IRQ (LOW_WM=2) asserts once count<=2.
- ready=0 with word 0x10 presented, enable dropped -> tx_data_o holds 0x10, no fifo_rd_o; ready=1 -> accepted, state returns IDLE.
- Fill 16 words, write 17th with ready=0 -> overrun_o=1; repeat with ready=1 the same cycle -> overrun_o stays 0; overrun_clr_i -> 0.
- flush_i one cycle while VALID with 5 queued -> fifo_rst_o=1 one cycle, tx_valid_o=0; host write in that cycle discarded; idle_o=1 after.
- rst_ni low mid-stream -> tx_valid_o=0 and fifo_rst_o=1 immediately without a clock edge; resumes cleanly after release.
